// File: rtl/morse_symbol_decoder.sv
// morse_symbol_decoder: times key presses into dots and lines
// and packs them into letters that an idle gap closes.
// Ports:
//   clock        rising-edge system clock
//   resetn       synchronous, active-low reset
//   user_input   raw key, 0 = pressed, asynchronous
//   ld_dot       1-cycle pulse per classified dot
//   ld_line      1-cycle pulse per classified line
//   letter_valid 1-cycle pulse when a letter closes
//   letter_code  letter symbols, dot=0 line=1, last in bit 0
//   letter_len   symbol count of letter_code
//   letter_err   closed letter overflowed MAX_SYMBOLS
module morse_symbol_decoder #(
  parameter int CNT_W       = 8,
  parameter int DOT_MIN     = 2,
  parameter int LINE_MIN    = 6,
  parameter int GAP_CYCLES  = 10,
  parameter int MAX_SYMBOLS = 5,
  localparam int LEN_W = $clog2(MAX_SYMBOLS + 1)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   user_input,
  output logic                   ld_dot,
  output logic                   ld_line,
  output logic                   letter_valid,
  output logic [MAX_SYMBOLS-1:0] letter_code,
  output logic [LEN_W-1:0]       letter_len,
  output logic                   letter_err
);

  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_DOT  = CNT_W'(DOT_MIN);
  localparam logic [CNT_W-1:0] C_LINE = CNT_W'(LINE_MIN);
  localparam logic [CNT_W-1:0] C_GAP  = CNT_W'(GAP_CYCLES);
  localparam logic [LEN_W-1:0] C_MAX  = LEN_W'(MAX_SYMBOLS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t                 r_state, w_state_nx;
  logic                   r_sync1, r_sync2;
  logic [1:0]             r_vld;
  logic                   r_armed;
  logic [CNT_W-1:0]       r_press, w_press_nx;
  logic [CNT_W-1:0]       r_gap, w_gap_nx;
  logic [MAX_SYMBOLS-1:0] r_sym, w_sym_nx;
  logic [LEN_W-1:0]       r_len, w_len_nx;
  logic                   r_ovf, w_ovf_nx;
  logic                   w_dot, w_line, w_emit;
  logic                   w_key, w_bit;
  logic                   r_ld_dot, r_ld_line, r_valid;
  logic [MAX_SYMBOLS-1:0] r_code;
  logic [LEN_W-1:0]       r_len_o;
  logic                   r_err;

  assign w_key = ~r_sync2;
  assign w_bit = (r_press >= C_LINE);

  always_comb begin
    w_state_nx = r_state;
    w_press_nx = r_press;
    w_gap_nx   = r_gap;
    w_sym_nx   = r_sym;
    w_len_nx   = r_len;
    w_ovf_nx   = r_ovf;
    w_dot      = 1'b0;
    w_line     = 1'b0;
    w_emit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // a key held through reset is ignored until released
        if (w_key && r_armed) begin
          w_state_nx = S_PRESS;
          w_press_nx = C_ONE;
        end
      end
      S_PRESS: begin
        if (w_key) begin
          if (r_press != C_LINE) w_press_nx = r_press + C_ONE;
        end else if (r_press < C_DOT) begin
          w_gap_nx   = '0;
          w_state_nx = (r_len != '0) ? S_GAP : S_IDLE;
        end else begin
          w_dot  = ~w_bit;
          w_line = w_bit;
          if (r_len < C_MAX) begin
            w_sym_nx = (r_sym << 1) | MAX_SYMBOLS'(w_bit);
            w_len_nx = r_len + LEN_W'(1);
          end else begin
            w_ovf_nx = 1'b1;
          end
          w_gap_nx   = C_ONE;
          w_state_nx = S_GAP;
        end
      end
      S_GAP: begin
        if (w_key) begin
          w_state_nx = S_PRESS;
          w_press_nx = C_ONE;
          w_gap_nx   = '0;
        end else if (r_gap == C_GAP) begin
          w_state_nx = S_EMIT;
          w_emit     = 1'b1;
        end else begin
          w_gap_nx = r_gap + C_ONE;
        end
      end
      S_EMIT: begin
        w_sym_nx = '0;
        w_len_nx = '0;
        w_ovf_nx = 1'b0;
        w_gap_nx = '0;
        if (w_key) begin
          w_state_nx = S_PRESS;
          w_press_nx = C_ONE;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_vld     <= '0;
      r_armed   <= 1'b0;
      r_state   <= S_IDLE;
      r_press   <= '0;
      r_gap     <= '0;
      r_sym     <= '0;
      r_len     <= '0;
      r_ovf     <= 1'b0;
      r_ld_dot  <= 1'b0;
      r_ld_line <= 1'b0;
      r_valid   <= 1'b0;
      r_code    <= '0;
      r_len_o   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_sync1   <= user_input;
      r_sync2   <= r_sync1;
      // r_vld[1] marks r_sync2 as holding a real sample
      r_vld     <= {r_vld[0], 1'b1};
      r_armed   <= r_armed | (r_vld[1] & r_sync2);
      r_state   <= w_state_nx;
      r_press   <= w_press_nx;
      r_gap     <= w_gap_nx;
      r_sym     <= w_sym_nx;
      r_len     <= w_len_nx;
      r_ovf     <= w_ovf_nx;
      r_ld_dot  <= w_dot;
      r_ld_line <= w_line;
      r_valid   <= w_emit;
      if (w_emit) begin
        r_code  <= r_sym;
        r_len_o <= r_len;
        r_err   <= r_ovf;
      end
    end
  end

  assign ld_dot       = r_ld_dot;
  assign ld_line      = r_ld_line;
  assign letter_valid = r_valid;
  assign letter_code  = r_code;
  assign letter_len   = r_len_o;
  assign letter_err   = r_err;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// tb_morse_symbol_decoder: drives press/release segments and
// checks the pulse and letter events against a segment model.
module tb_morse_symbol_decoder;

  localparam int DOT  = 2;
  localparam int LINE = 6;
  localparam int GAP  = 10;
  localparam int MAXS = 5;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       user_input = 1'b1;
  logic       ld_dot, ld_line, letter_valid, letter_err;
  logic [4:0] letter_code;
  logic [2:0] letter_len;

  morse_symbol_decoder #(
    .CNT_W(8), .DOT_MIN(DOT), .LINE_MIN(LINE),
    .GAP_CYCLES(GAP), .MAX_SYMBOLS(MAXS)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .user_input(user_input),
    .ld_dot(ld_dot),
    .ld_line(ld_line),
    .letter_valid(letter_valid),
    .letter_code(letter_code),
    .letter_len(letter_len),
    .letter_err(letter_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    int         slot;
    logic [1:0] kind;
    logic [4:0] code;
    logic [2:0] len;
    logic       err;
  } ev_t;

  typedef struct packed {
    int l;
    int r;
  } seg_t;

  ev_t  act_q[$];
  ev_t  exp_q[$];
  seg_t segs[$];
  int   slot = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   m_pend = 0;
  int   m_len = 0;
  int   m_code = 0;
  bit   m_ovf = 0;
  logic [4:0] p_code;
  logic [2:0] p_len;
  logic       p_err;

  always @(posedge clock) slot <= slot + 1;

  always @(posedge clock) begin
    #1;
    if (ld_dot)
      act_q.push_back('{slot, 2'd0, 5'd0, 3'd0, 1'b0});
    if (ld_line)
      act_q.push_back('{slot, 2'd1, 5'd0, 3'd0, 1'b0});
    if (letter_valid)
      act_q.push_back('{slot, 2'd2, letter_code,
                        letter_len, letter_err});
    n_vec++;
    if (ld_dot && ld_line) begin
      n_err++;
      $display("FAIL excl slot %0d dot and line both 1", slot);
    end
    if (resetn && !letter_valid &&
        {letter_code, letter_len, letter_err} !==
        {p_code, p_len, p_err}) begin
      n_err++;
      $display("FAIL hold slot %0d got %h want %h", slot,
               {letter_code, letter_len, letter_err},
               {p_code, p_len, p_err});
    end
    p_code = letter_code;
    p_len  = letter_len;
    p_err  = letter_err;
  end

  // Model: a press of L slots whose release starts at slot r0
  // pulses at r0+3 (2 sync stages + registered output).  A
  // letter closes once the release run reaches GAP+1 slots
  // after a symbol, or GAP+2 slots after a glitch.
  task automatic play();
    int t, r0, need, off;
    bit b;
    t = slot;
    foreach (segs[i]) begin
      r0 = t + segs[i].l;
      if (segs[i].l < DOT) begin
        need = GAP + 2;
        off  = GAP + 4;
      end else begin
        b = (segs[i].l >= LINE);
        exp_q.push_back('{r0 + 3, b ? 2'd1 : 2'd0,
                          5'd0, 3'd0, 1'b0});
        if (m_len < MAXS) begin
          m_code = m_code * 2 + int'(b);
          m_len++;
        end else begin
          m_ovf = 1;
        end
        m_pend = 1;
        need = GAP + 1;
        off  = GAP + 3;
      end
      if (m_pend && segs[i].r >= need) begin
        exp_q.push_back('{r0 + off, 2'd2, 5'(m_code),
                          3'(m_len), m_ovf});
        m_pend = 0;
        m_len  = 0;
        m_code = 0;
        m_ovf  = 0;
      end
      t = r0 + segs[i].r;
    end
    foreach (segs[i]) begin
      user_input = 1'b0;
      repeat (segs[i].l) @(negedge clock);
      user_input = 1'b1;
      repeat (segs[i].r) @(negedge clock);
    end
    segs.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    user_input = 1'b1;
    repeat (3) @(negedge clock);
    n_vec++;
    if (ld_dot !== 1'b0) begin
      n_err++; $display("FAIL rst_dot got %b want 0", ld_dot);
    end
    n_vec++;
    if (ld_line !== 1'b0) begin
      n_err++; $display("FAIL rst_line got %b want 0", ld_line);
    end
    n_vec++;
    if (letter_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_valid got %b want 0", letter_valid);
    end
    n_vec++;
    if (letter_code !== 5'd0) begin
      n_err++;
      $display("FAIL rst_code got %b want 0", letter_code);
    end
    n_vec++;
    if (letter_len !== 3'd0) begin
      n_err++;
      $display("FAIL rst_len got %0d want 0", letter_len);
    end
    n_vec++;
    if (letter_err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_err got %b want 0", letter_err);
    end
    resetn = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_single_dot();
    @(negedge clock);
    act_q.delete(); exp_q.delete();
    segs.push_back('{3, 20});
    play();
    repeat (4) @(negedge clock);
    n_vec++;
    if (act_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL dot_cnt got %0d want %0d",
               act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL dot_ev%0d got %h want %h",
                 i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_letter_w();
    @(negedge clock);
    act_q.delete(); exp_q.delete();
    segs.push_back('{3, 2});
    segs.push_back('{8, 2});
    segs.push_back('{8, 20});
    play();
    repeat (4) @(negedge clock);
    n_vec++;
    if (act_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL w_cnt got %0d want %0d",
               act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL w_ev%0d got %h want %h",
                 i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    @(negedge clock);
    act_q.delete(); exp_q.delete();
    segs.push_back('{5, 20});
    segs.push_back('{6, 20});
    segs.push_back('{300, 20});
    segs.push_back('{1, 20});
    segs.push_back('{3, 9});
    segs.push_back('{6, 20});
    segs.push_back('{3, 10});
    segs.push_back('{6, 20});
    segs.push_back('{3, 4});
    segs.push_back('{1, 11});
    segs.push_back('{6, 20});
    segs.push_back('{3, 4});
    segs.push_back('{1, 12});
    segs.push_back('{2, 20});
    play();
    repeat (4) @(negedge clock);
    n_vec++;
    if (act_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL bnd_cnt got %0d want %0d",
               act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL bnd_ev%0d got %h want %h",
                 i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    @(negedge clock);
    act_q.delete(); exp_q.delete();
    repeat (5) segs.push_back('{3, 2});
    segs.push_back('{3, 20});
    segs.push_back('{3, 20});
    play();
    repeat (4) @(negedge clock);
    n_vec++;
    if (act_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL ovf_cnt got %0d want %0d",
               act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL ovf_ev%0d got %h want %h",
                 i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    act_q.delete(); exp_q.delete();
    segs.push_back('{3, 11});
    segs.push_back('{3, 20});
    segs.push_back('{6, 1});
    segs.push_back('{3, 1});
    segs.push_back('{2, 20});
    play();
    repeat (4) @(negedge clock);
    n_vec++;
    if (act_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL b2b_cnt got %0d want %0d",
               act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL b2b_ev%0d got %h want %h",
                 i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    act_q.delete(); exp_q.delete();
    user_input = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    n_vec++;
    if ({ld_dot, ld_line, letter_valid, letter_code,
         letter_len, letter_err} !== 12'd0) begin
      n_err++;
      $display("FAIL rmid_press_out got %h want 0",
               {ld_dot, ld_line, letter_valid, letter_code,
                letter_len, letter_err});
    end
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    user_input = 1'b1;
    repeat (20) @(negedge clock);
    segs.push_back('{3, 2});
    segs.push_back('{8, 3});
    play();
    resetn = 1'b0;
    m_pend = 0; m_len = 0; m_code = 0; m_ovf = 0;
    @(negedge clock);
    n_vec++;
    if ({ld_dot, ld_line, letter_valid, letter_code,
         letter_len, letter_err} !== 12'd0) begin
      n_err++;
      $display("FAIL rmid_pend_out got %h want 0",
               {ld_dot, ld_line, letter_valid, letter_code,
                letter_len, letter_err});
    end
    resetn = 1'b1;
    repeat (25) @(negedge clock);
    segs.push_back('{3, 20});
    play();
    repeat (4) @(negedge clock);
    n_vec++;
    if (act_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rmid_cnt got %0d want %0d",
               act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rmid_ev%0d got %h want %h",
                 i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int l, r;
    @(negedge clock);
    act_q.delete(); exp_q.delete();
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) l = $urandom_range(7, 40);
      else l = $urandom_range(1, 7);
      r = (k == 59) ? 20 : $urandom_range(1, 14);
      segs.push_back('{l, r});
    end
    play();
    repeat (4) @(negedge clock);
    n_vec++;
    if (act_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rnd_cnt got %0d want %0d",
               act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rnd_ev%0d got %h want %h",
                 i, act_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_dot();
    test_letter_w();
    test_boundaries();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
